// File: rtl/print_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : print_ctrl_pkg
// Brief  : Shared state encoding and constants for the string print controller.
// Rev    : 1.0  initial release
// ============================================================================
package print_ctrl_pkg;

    localparam int         C_OFFSET_W = 2;
    localparam logic [7:0] C_NUL_CHAR = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/string_print_ctrl_byte_lane_sel.sv
`default_nettype none
// ============================================================================
// Module : byte_lane_sel
// Brief  : Little-endian byte extraction from a 32-bit word by byte offset.
// Rev    : 1.0  initial release
// ============================================================================
module byte_lane_sel
    import print_ctrl_pkg::*;
(
    input  logic [31:0]           word,
    input  logic [C_OFFSET_W-1:0] offset,
    output logic [7:0]            lane
);

    always_comb begin
        lane = word[7:0];
        case (offset)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            2'd3:    lane = word[31:24];
            default: lane = word[7:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/string_print_ctrl.sv
`default_nettype none
// ============================================================================
// Module : string_print_ctrl
// Brief  : Walks a NUL-terminated string in word memory and streams its bytes
//          to a valid/ready character sink. Define PRINT_LEN_LIMIT_EN to cap
//          each request at MAX_LEN characters and flag len_err.
// Rev    : 1.0  initial release
// ============================================================================
module string_print_ctrl
    import print_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a0,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    state_t                r_state;
    logic [31:0]           r_ptr;
    logic [31:0]           r_word;
    logic [31:0]           w_ptr_next;
    logic [31:0]           w_sel_word;
    logic [C_OFFSET_W-1:0] w_sel_off;
    logic [7:0]            w_lane;
    logic                  w_handshake;
    logic                  w_last_in_word;
    logic                  w_limit_hit;

    assign w_ptr_next     = r_ptr + 32'd1;
    assign w_handshake    = (r_state == ST_EMIT) && char_valid && char_ready;
    assign w_last_in_word = (r_ptr[C_OFFSET_W-1:0] == 2'd3);

    // WAIT inspects the word arriving now so the first char is valid on EMIT entry;
    // EMIT looks one byte ahead so the next char is ready right after a handshake.
    assign w_sel_word = (r_state == ST_WAIT) ? mem_rdata : r_word;
    assign w_sel_off  = (r_state == ST_WAIT) ? r_ptr[C_OFFSET_W-1:0]
                                             : w_ptr_next[C_OFFSET_W-1:0];

    byte_lane_sel u_byte_lane_sel (
        .word   (w_sel_word),
        .offset (w_sel_off),
        .lane   (w_lane)
    );

`ifdef PRINT_LEN_LIMIT_EN
    localparam int C_CNT_W = ($clog2(MAX_LEN + 1) > 9) ? $clog2(MAX_LEN + 1) : 9;

    logic [C_CNT_W-1:0] r_count;

    assign w_limit_hit = ((r_count + 1'b1) == C_CNT_W'(MAX_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            len_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_count <= '0;
            len_err <= 1'b0;
        end else if (w_handshake) begin
            r_count <= r_count + 1'b1;
            if (w_limit_hit)
                len_err <= 1'b1;
        end
    end
`else
    assign w_limit_hit = 1'b0;
    assign len_err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 32'd0;
            r_word     <= 32'd0;
            mem_rd     <= 1'b0;
            mem_addr   <= 32'd0;
            char_valid <= 1'b0;
            char_data  <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done   <= 1'b0;
            mem_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ptr    <= a0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= {a0[31:2], 2'b00};
                        r_state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_word     <= mem_rdata;
                    char_valid <= (w_lane != C_NUL_CHAR);
                    char_data  <= w_lane;
                    r_state    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (!char_valid) begin
                        // Current byte is the terminator.
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_FINISH;
                    end else if (char_ready) begin
                        r_ptr <= w_ptr_next;
                        if (w_limit_hit) begin
                            char_valid <= 1'b0;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= ST_FINISH;
                        end else if (w_last_in_word) begin
                            char_valid <= 1'b0;
                            mem_rd     <= 1'b1;
                            mem_addr   <= {w_ptr_next[31:2], 2'b00};
                            r_state    <= ST_FETCH;
                        end else begin
                            char_valid <= (w_lane != C_NUL_CHAR);
                            if (w_lane != C_NUL_CHAR)
                                char_data <= w_lane;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_string_print_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_string_print_ctrl
// Brief  : Self-checking bench for string_print_ctrl with a word memory model
//          and a character scoreboard; honours PRINT_LEN_LIMIT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module tb_string_print_ctrl;

`ifdef PRINT_LEN_LIMIT_EN
    localparam int TB_MAX_LEN = 4;
    localparam bit TB_LIMIT   = 1'b1;
`else
    localparam int TB_MAX_LEN = 256;
    localparam bit TB_LIMIT   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a0 = 32'd0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        len_err;

    string_print_ctrl #(.MAX_LEN(TB_MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a0         (a0),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [logic [31:0]];

    always @(posedge clk)
        if (mem_rd)
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];
    int          rd_cnt = 0;
    int          done_cnt = 0;

    // Scoreboard: every accepted character is popped against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                rd_cnt++;
                addr_q.push_back(mem_addr);
            end
            if (done)
                done_cnt++;
            if (char_valid && char_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL char_unexpected: got %02h, required no character", char_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (char_data !== e) begin
                        errors++;
                        $display("FAIL char_data: got %02h, required %02h", char_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic put_byte(input logic [31:0] addr, input logic [7:0] b);
        logic [31:0] wa;
        logic [31:0] w;
        wa = {addr[31:2], 2'b00};
        w  = mem.exists(wa) ? mem[wa] : 32'h0;
        w[addr[1:0]*8 +: 8] = b;
        mem[wa] = w;
    endtask

    task automatic load_string(input logic [31:0] base, input string text);
        mem.delete();
        for (int i = 0; i < text.len(); i++)
            put_byte(base + 32'(i), text[i]);
        put_byte(base + 32'(text.len()), 8'h00);
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        @(posedge clk); #1;
        a0    = addr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rand_ready);
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(posedge clk); #1;
            if (rand_ready)
                char_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
        end
    endtask

    task automatic run_vec(input logic [31:0] base, input string text,
                           input logic [31:0] first_addr, input bit rand_ready);
        int  len;
        int  n;
        int  exp_rd;
        bit  trunc;
        load_string(base, text);
        len   = text.len();
        trunc = TB_LIMIT && (len >= TB_MAX_LEN);
        for (int i = 0; i < (trunc ? TB_MAX_LEN : len); i++)
            exp_q.push_back(text[i]);
        n      = trunc ? TB_MAX_LEN : len + 1;
        exp_rd = (int'(base[1:0]) + n - 1) / 4 + 1;
        rd_cnt = 0;
        done_cnt = 0;
        addr_q.delete();
        char_ready = 1'b1;
        pulse_start(base);
        check({"busy_after_start ", text}, 64'(busy), 64'd1);
        check({"len_err_after_start ", text}, 64'(len_err), 64'd0);
        wait_done(rand_ready);
        char_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({"chars_left ", text}, 64'(exp_q.size()), 64'd0);
        check({"mem_rd_count ", text}, 64'(rd_cnt), 64'(exp_rd));
        check({"done_count ", text}, 64'(done_cnt), 64'd1);
        check({"first_mem_addr ", text}, 64'(addr_q.size() > 0 ? addr_q[0] : 32'hDEAD_BEEF),
              64'(first_addr));
        check({"busy_after_done ", text}, 64'(busy), 64'd0);
        check({"len_err_after_done ", text}, 64'(len_err), 64'(trunc));
        if (trunc) begin
            repeat (3) @(posedge clk);
            #1;
            check({"len_err_hold ", text}, 64'(len_err), 64'd1);
        end
        exp_q.delete();
        char_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a0;
        string       text;
        logic [31:0] first_addr;
        bit          rand_ready;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{32'h0040_0000, "Hi",          32'h0040_0000, 1'b0};
        vecs[1] = '{32'h0040_0003, "ABCD",        32'h0040_0000, 1'b0};
        vecs[2] = '{32'h0040_1000, "",            32'h0040_1000, 1'b0};
        vecs[3] = '{32'h0040_2001, "hello world", 32'h0040_2000, 1'b1};
        vecs[4] = '{32'h0040_3000, "abcdefghij",  32'h0040_3000, 1'b0};
        vecs[5] = '{32'hFFFF_FFFE, "xyz",         32'hFFFF_FFFC, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({mem_rd, mem_addr, char_valid, char_data, busy, done, len_err}),
              64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i].a0, vecs[i].text, vecs[i].first_addr, vecs[i].rand_ready);

        // Back-pressure on the first char, with a start pulse that must be ignored.
        load_string(32'h0040_0000, "Hi");
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        rd_cnt = 0;
        done_cnt = 0;
        char_ready = 1'b0;
        @(posedge clk); #1;
        a0 = 32'h0040_0000;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end while (!char_valid && cyc < 20);
        check("first_char_latency", 64'(cyc), 64'd3);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(char_valid), 64'd1);
            check("stall_data", 64'(char_data), 64'h48);
            a0    = 32'h0040_9000;
            start = (i == 2);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("stall_mem_rd", 64'(rd_cnt), 64'd1);
        char_ready = 1'b1;
        wait_done(1'b0);
        @(posedge clk); #1;
        check("stall_chars_left", 64'(exp_q.size()), 64'd0);
        check("stall_done_count", 64'(done_cnt), 64'd1);
        check("stall_total_mem_rd", 64'(rd_cnt), 64'd1);

        // Empty string: done three cycles after FETCH entry.
        load_string(32'h0040_1000, "");
        done_cnt = 0;
        char_ready = 1'b1;
        @(posedge clk); #1;
        a0 = 32'h0040_1000;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 20);
        check("empty_done_latency", 64'(cyc), 64'd4);

        // Asynchronous reset while the second char is waiting.
        repeat (2) @(posedge clk);
        load_string(32'h0040_0000, "Hi");
        exp_q.push_back(8'h48);
        done_cnt = 0;
        char_ready = 1'b0;
        pulse_start(32'h0040_0000);
        cyc = 0;
        while (!char_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        char_ready = 1'b1;
        @(posedge clk); #1;
        char_ready = 1'b0;
        check("second_char_before_reset", 64'({char_valid, char_data}), 64'h169);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_request", 64'({mem_rd, mem_addr, char_valid, char_data, busy, done, len_err}),
              64'd0);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(done_cnt), 64'd0);
        check("reset_chars_left", 64'(exp_q.size()), 64'd0);
        run_vec(32'h0040_4002, "Ok", 32'h0040_4000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/string_print_ctrl.md
STRING_PRINT_CTRL -- requirements
Module: string_print_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 256: maximum characters emitted per request (limiter build only).
REQ-002 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1: print request pulse (syscall print-string).
REQ-005 SHALL have port a0, input, 32: byte address of the NUL-terminated string, sampled with start.
REQ-006 SHALL have port mem_rd, output, 1: word read strobe to data memory.
REQ-007 SHALL have port mem_addr, output, 32: word-aligned byte address, bits [1:0] = 0.
REQ-008 SHALL have port mem_rdata, input, 32: read word, valid the cycle after mem_rd.
REQ-009 SHALL have port char_valid, output, 1: char_data holds a character.
REQ-010 SHALL have port char_data, output, 8: character byte.
REQ-011 SHALL have port char_ready, input, 1: sink accepts the character when high with char_valid.
REQ-012 SHALL have ports busy (1) and done (1), outputs: request in progress; one-cycle completion pulse.
REQ-013 SHALL have port len_err, output, 1: set when MAX_LEN is reached without a NUL (limiter build only, else tied 0).

Function
REQ-014 SHALL implement states IDLE, FETCH, WAIT, EMIT, FINISH.
REQ-015 IDLE: start=1 SHALL latch ptr=a0, set busy the next cycle, go to FETCH; start while busy SHALL be ignored.
REQ-016 FETCH: mem_rd=1 and mem_addr={ptr[31:2],2'b00} for exactly one cycle, then WAIT.
REQ-017 WAIT: mem_rdata SHALL be captured into a word register, then EMIT.
REQ-018 Byte select SHALL be little-endian: offset 0->[7:0], 1->[15:8], 2->[23:16], 3->[31:24].
REQ-019 EMIT: if the selected byte is 8'h00, go to FINISH without asserting char_valid; the NUL is never emitted.
REQ-020 EMIT, non-NUL: char_valid=1, char_data held stable until char_ready; on handshake ptr increments by 1.
REQ-021 After handshake: if old offset was 3 (wrap to next word), go to FETCH; else stay in EMIT on the same word without a memory read.
REQ-022 FINISH: done=1 for one cycle, busy cleared, return to IDLE.
REQ-023 ptr arithmetic SHALL be 32-bit unsigned with wrap from 32'hFFFF_FFFF to 0.
REQ-024 Minimum latency start->first char_valid SHALL be 3 cycles (IDLE->FETCH->WAIT->EMIT).
REQ-025 char_ready without char_valid SHALL have no effect.

Reset
REQ-026 rst_n low SHALL force IDLE asynchronously, including mid-request; the request is abandoned and done is not pulsed.
REQ-027 Reset values SHALL be: mem_rd=0, mem_addr=0, char_valid=0, char_data=0, busy=0, done=0, len_err=0, internal ptr/count/word = 0.

Configuration
REQ-028 With PRINT_LEN_LIMIT_EN defined, a 9+-bit counter SHALL count emitted chars; after the MAX_LEN-th handshake with no NUL, the controller SHALL go to FINISH and set len_err, which holds until the next start.
REQ-029 Without PRINT_LEN_LIMIT_EN, no counter SHALL exist, strings are unbounded, and len_err is constant 0.

Structure
REQ-030 A shared package print_ctrl_pkg SHALL hold the state enum, the NUL constant 8'h00, and the byte-offset width.
REQ-031 One sub-module byte_lane_sel (32-bit word + 2-bit offset -> 8-bit byte, combinational) SHALL perform the REQ-018 selection.

Verification
REQ-032 mem holds "Hi\0" at 0x00400000 (word 0x0000_6948); start, a0=0x00400000, char_ready=1 -> chars 0x48, 0x69, then done; exactly 1 mem_rd.
REQ-033 a0=0x00400003, string "ABCD\0" across two words -> first mem_addr 0x00400000, second 0x00400004; chars A,B,C,D; 2 mem_rd.
REQ-034 char_ready held low 5 cycles on the first char -> char_valid/char_data stable for all 5 cycles, ptr unchanged, no extra mem_rd.
REQ-035 Empty string (byte 0x00 at a0) -> no char_valid, done pulses 3 cycles after FETCH entry.
REQ-036 rst_n asserted during EMIT of the 2nd char -> outputs zero immediately, no done; a new start then prints from its own a0.
REQ-037 PRINT_LEN_LIMIT_EN, MAX_LEN=4, 10-char string with no NUL -> exactly 4 chars, done pulse, len_err=1 until the next start.
